// File: rtl/addsub_simd_pipe.sv
// rtl/addsub_simd_pipe.sv - two-stage elastic SIMD add/sub with per-lane wrap/saturate and sticky overflow count
module addsub_simd_pipe #(
    parameter int LANES = 4,
    parameter int WIDTH = 12,
    parameter int CNT_W = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic                   op_sat,
    input  logic [LANES*WIDTH-1:0] a_vec,
    input  logic [LANES*WIDTH-1:0] b_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_vec,
    output logic [LANES-1:0]       out_ovf,
    input  logic                   clr_count,
    output logic [CNT_W-1:0]       ovf_count
);

    localparam int VW = LANES * WIDTH;

    logic          s1_valid;
    logic          s1_sub;
    logic          s1_sat;
    logic [VW-1:0] s1_a;
    logic [VW-1:0] s1_b;
    logic          s2_valid;
    logic          s1_en;
    logic          s2_en;

    logic [VW-1:0]    lane_res;
    logic [LANES-1:0] lane_ovf;

    // Each stage advances when its downstream slot is free or draining this cycle.
    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    // Per-lane arithmetic on WIDTH+1 bits; lanes never share a carry chain.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] a_l;
        logic [WIDTH-1:0] b_l;
        logic [WIDTH:0]   a_x;
        logic [WIDTH:0]   b_x;
        logic [WIDTH:0]   r;

        assign a_l = s1_a[i*WIDTH +: WIDTH];
        assign b_l = s1_b[i*WIDTH +: WIDTH];
        assign a_x = {a_l[WIDTH-1], a_l};
        assign b_x = {b_l[WIDTH-1], b_l};
        assign r   = s1_sub ? (a_x - b_x) : (a_x + b_x);

        // The extra sign bit disagreeing with the lane MSB means the true result left range.
        assign lane_ovf[i] = r[WIDTH] ^ r[WIDTH-1];

        // r[WIDTH] is the true sign, so it picks the rail to clamp to.
        assign lane_res[i*WIDTH +: WIDTH] =
            (s1_sat && lane_ovf[i]) ?
                (r[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
                r[WIDTH-1:0];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s1_sub   <= 1'b0;
            s1_sat   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            out_vec  <= '0;
            out_ovf  <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sub <= op_sub;
                    s1_sat <= op_sat;
                    s1_a   <= a_vec;
                    s1_b   <= b_vec;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                // Result registers only move on a real transfer so the last value holds when empty.
                if (s1_valid) begin
                    out_vec <= lane_res;
                    out_ovf <= lane_ovf;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= '0;
        end else if (s2_valid && out_ready && (|out_ovf) && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_addsub_simd_pipe.sv
// tb/tb_addsub_simd_pipe.sv - randomized self-checking bench for addsub_simd_pipe
module tb_addsub_simd_pipe;

    localparam int LANES = 4;
    localparam int WIDTH = 12;
    localparam int CNT_W = 6;
    localparam int VW    = LANES * WIDTH;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op_sub = 1'b0;
    logic             op_sat = 1'b0;
    logic [VW-1:0]    a_vec = '0;
    logic [VW-1:0]    b_vec = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [VW-1:0]    out_vec;
    logic [LANES-1:0] out_ovf;
    logic             clr_count = 1'b0;
    logic [CNT_W-1:0] ovf_count;

    int n_cmp = 0;
    int n_bad = 0;

    addsub_simd_pipe #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .op_sat    (op_sat),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference: integer arithmetic on the true signed values, then range check.
    function automatic logic [LANES+VW-1:0] ref_model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                        input logic sub, input logic sat);
        logic [VW-1:0]    v;
        logic [LANES-1:0] o;
        int mx, mn;
        mx = (1 << (WIDTH-1)) - 1;
        mn = -(1 << (WIDTH-1));
        v = '0;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            int ia, ib, r;
            logic [WIDTH-1:0] sa, sb;
            sa = a[i*WIDTH +: WIDTH];
            sb = b[i*WIDTH +: WIDTH];
            ia = int'($signed(sa));
            ib = int'($signed(sb));
            r  = sub ? ia - ib : ia + ib;
            if (r > mx || r < mn) begin
                o[i] = 1'b1;
                if (sat) r = (r > mx) ? mx : mn;
            end
            v[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
        end
        return {o, v};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // Single transaction on an idle pipe with out_ready high; checks latency and result.
    task automatic send_one(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input logic sub, input logic sat,
                            input logic [VW-1:0] ev, input logic [LANES-1:0] eo);
        out_ready = 1'b1;
        a_vec = a; b_vec = b; op_sub = sub; op_sat = sat; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready got %b want 1", name, in_ready); end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s early_valid got %b want 0", name, out_valid); end
        @(posedge ap_clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s latency out_valid got %b want 1", name, out_valid); end
        n_cmp++;
        if (out_vec !== ev) begin n_bad++; $display("FAIL %s out_vec got %h want %h", name, out_vec, ev); end
        n_cmp++;
        if (out_ovf !== eo) begin n_bad++; $display("FAIL %s out_ovf got %b want %b", name, out_ovf, eo); end
        @(posedge ap_clk); #1;
    endtask

    // Push n identical transactions with out_ready high and wait until all are consumed.
    task automatic run_stream(input int n, input logic [VW-1:0] a, input logic [VW-1:0] b);
        int acc = 0;
        int done = 0;
        a_vec = a; b_vec = b; op_sub = 1'b0; op_sat = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < n + 20 && done < n; c++) begin
            in_valid = (acc < n);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) done++;
            @(posedge ap_clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (done != n) begin n_bad++; $display("FAIL stream_drain got %0d want %0d", done, n); end
    endtask

    task automatic test_reset();
        #1 ap_rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (out_vec !== '0) begin n_bad++; $display("FAIL rst_out_vec got %h want 0", out_vec); end
        n_cmp++;
        if (out_ovf !== '0) begin n_bad++; $display("FAIL rst_out_ovf got %b want 0", out_ovf); end
        n_cmp++;
        if (ovf_count !== '0) begin n_bad++; $display("FAIL rst_ovf_count got %0d want 0", ovf_count); end
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [VW-1:0] a1, a2, ones, allf;
        a1   = {12'h123, 12'h123, 12'h123, 12'h7FF};
        a2   = {12'h123, 12'h123, 12'h123, 12'h800};
        ones = {12'h001, 12'h001, 12'h001, 12'h001};
        allf = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        send_one("add_wrap", a1, ones, 1'b0, 1'b0, {12'h124, 12'h124, 12'h124, 12'h800}, 4'b0001);
        send_one("add_sat",  a1, ones, 1'b0, 1'b1, {12'h124, 12'h124, 12'h124, 12'h7FF}, 4'b0001);
        send_one("sub_sat",  a2, ones, 1'b1, 1'b1, {12'h122, 12'h122, 12'h122, 12'h800}, 4'b0001);
        send_one("sub_wrap", a2, ones, 1'b1, 1'b0, {12'h122, 12'h122, 12'h122, 12'h7FF}, 4'b0001);
        send_one("isolate",  allf, ones, 1'b0, 1'b0, '0, 4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [LANES+VW-1:0] q[$];
        logic [LANES+VW-1:0] exp;
        logic [VW-1:0] na, nb;
        logic ns, nt;
        int pushed = 0;
        int popped = 0;
        na = rand_vec(); nb = rand_vec(); ns = 1'($urandom); nt = 1'($urandom);
        for (int c = 0; c < 300 && popped < 10; c++) begin
            in_valid  = (pushed < 10);
            a_vec = na; b_vec = nb; op_sub = ns; op_sat = nt;
            out_ready = 1'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== !((pushed - popped) == 2 && !out_ready)) begin
                n_bad++;
                $display("FAIL bp_in_ready got %b want %b (in flight %0d)", in_ready,
                         !((pushed - popped) == 2 && !out_ready), pushed - popped);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra got %h want none", out_vec);
                end else begin
                    exp = q.pop_front();
                    if ({out_ovf, out_vec} !== exp) begin
                        n_bad++; $display("FAIL bp_data[%0d] got %h want %h", popped, {out_ovf, out_vec}, exp);
                    end
                end
                popped++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(na, nb, ns, nt));
                pushed++;
                na = rand_vec(); nb = rand_vec(); ns = 1'($urandom); nt = 1'($urandom);
            end
            @(posedge ap_clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (popped != 10) begin n_bad++; $display("FAIL bp_count got %0d want 10", popped); end
    endtask

    task automatic test_counter();
        logic [VW-1:0] ova, ovb;
        int w;
        ova = {12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};
        ovb = {12'h001, 12'h001, 12'h001, 12'h001};
        clr_count = 1'b1;
        @(posedge ap_clk); #1;
        clr_count = 1'b0;
        n_cmp++;
        if (ovf_count !== '0) begin n_bad++; $display("FAIL cnt_clear got %0d want 0", ovf_count); end
        run_stream(3, ova, ovb);
        n_cmp++;
        if (ovf_count !== CNT_W'(3)) begin n_bad++; $display("FAIL cnt_three got %0d want 3", ovf_count); end
        run_stream(2, '0, ovb);
        n_cmp++;
        if (ovf_count !== CNT_W'(3)) begin n_bad++; $display("FAIL cnt_no_ovf got %0d want 3", ovf_count); end
        // Fourth overflowing result consumed on the same edge as clr_count.
        out_ready = 1'b0;
        a_vec = ova; b_vec = ovb; in_valid = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin @(posedge ap_clk); #1; w++; end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL cnt_wait got %b want 1", out_valid); end
        out_ready = 1'b1; clr_count = 1'b1;
        @(posedge ap_clk); #1;
        clr_count = 1'b0;
        n_cmp++;
        if (ovf_count !== '0) begin n_bad++; $display("FAIL cnt_clr_wins got %0d want 0", ovf_count); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL cnt_consumed got %b want 0", out_valid); end
        run_stream((1 << CNT_W) - 1, ova, ovb);
        n_cmp++;
        if (ovf_count !== {CNT_W{1'b1}}) begin n_bad++; $display("FAIL cnt_full got %0d want %0d", ovf_count, (1 << CNT_W) - 1); end
        run_stream(1, ova, ovb);
        n_cmp++;
        if (ovf_count !== {CNT_W{1'b1}}) begin n_bad++; $display("FAIL cnt_sat got %0d want %0d", ovf_count, (1 << CNT_W) - 1); end
    endtask

    task automatic test_reset_midstream();
        logic [VW-1:0] ra, rb;
        logic [LANES+VW-1:0] e;
        out_ready = 1'b0;
        a_vec = {12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};
        b_vec = {12'h001, 12'h001, 12'h001, 12'h001};
        op_sub = 1'b0; op_sat = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin @(posedge ap_clk); #1; end
        in_valid = 1'b0;
        #1 ap_rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        n_cmp++;
        if (ovf_count !== '0) begin n_bad++; $display("FAIL mid_rst_count got %0d want 0", ovf_count); end
        @(posedge ap_clk); #3;
        ap_rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge ap_clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale[%0d] got %b want 0", i, out_valid); end
        end
        ra = rand_vec(); rb = rand_vec();
        e = ref_model(ra, rb, 1'b1, 1'b1);
        send_one("post_rst", ra, rb, 1'b1, 1'b1, e[VW-1:0], e[LANES+VW-1:VW]);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_counter();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_simd_pipe.md
# addsub_simd_pipe

Parametrised, pipelined SIMD add/subtract unit: LANES independent signed WIDTH-bit lanes packed into one operand vector, with per-transaction add/sub and wrap/saturate mode. It is the elastic, streaming generation of the fixed four-lane 12-bit adder. It sits between HLS-generated producer and consumer stages with valid/ready handshakes on both sides, and keeps a per-lane overflow indication and a sticky overflow counter for debug.

## Interface
Parameters:
- LANES, 4, number of packed lanes (1..8)
- WIDTH, 12, bits per lane (4..24)
- CNT_W, 16, width of overflow counter

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept input this cycle
- op_sub  in  1  0 = a+b, 1 = a-b (sampled with transaction)
- op_sat  in  1  0 = wrap, 1 = signed saturate (sampled with transaction)
- a_vec  in  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH]
- b_vec  in  LANES*WIDTH  operand B, same packing
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_vec  out  LANES*WIDTH  per-lane result, same packing
- out_ovf  out  LANES  per-lane overflow flag for out_vec
- clr_count  in  1  synchronous clear of ovf_count
- ovf_count  out  CNT_W  number of consumed results with any out_ovf bit set

## Operation
- Two-stage elastic pipeline. S1 registers operands and mode bits; S2 computes and registers the result and flags. Each stage has a valid bit.
- Enables: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en (combinational, no combinational path from in_valid).
- Input handshake at in_valid & in_ready: S1 loads. S1 to S2 transfer when s1_valid & s2_en. When a stage is enabled but its source is empty, its valid clears.
- Lanes are fully isolated: no carry or borrow crosses a lane boundary.
- Per lane, sign-extend both operands to WIDTH+1 bits and compute r = a + b or a - b. ovf = r[WIDTH] ^ r[WIDTH-1].
- Wrap mode: result = r[WIDTH-1:0].
- Saturate mode: if ovf, result = 2^(WIDTH-1)-1 when r[WIDTH]=0, else -2^(WIDTH-1). Otherwise result = r[WIDTH-1:0].
- out_ovf reports overflow in both modes.
- ovf_count: on an output handshake (out_valid & out_ready) with |out_ovf, count increments by 1. It saturates at all-ones.
- clr_count sets the count to 0. If clr_count coincides with an increment, clear wins.
- out_vec and out_ovf hold stable while out_valid & !out_ready.

## Timing
- Reset values (async, immediate): s1_valid = s2_valid = 0, out_valid = 0, out_vec = 0, out_ovf = 0, ovf_count = 0. in_ready is 1 from the first cycle after reset deasserts.
- Reset mid-stream discards all in-flight transactions; no partial output is produced.
- Latency: a transaction accepted at edge k appears with out_valid = 1 after edge k+2.
- Throughput: 1 transaction/cycle while out_ready = 1.
- Full: both stages valid and out_ready = 0 gives in_ready = 0. When out_ready rises, in_ready rises in the same cycle, so accept and drain happen on the same edge.
- Empty: out_valid = 0. out_vec holds its last value; its value is don't-care for checking.
- No transaction is dropped or duplicated under any in_valid/out_ready pattern.

## Test plan
- Defaults, wrap mode, lane 0 = 0x7FF + 0x001 (other lanes 0x123 + 0x001): out lane0 = 0x800, out_ovf = 0b0001; other lanes = 0x124; result 2 cycles after accept.
- Same operands with op_sat = 1: lane0 = 0x7FF. Then op_sub = 1, lane0 = 0x800 - 0x001: sat gives 0x800 and wrap gives 0x7FF, ovf = 1 in both modes.
- Lane isolation: all lanes 0xFFF + 0x001 in wrap mode: every lane = 0x000 and out_ovf = 0, with no carry into neighbouring lanes.
- Backpressure: stream 10 transactions with in_valid held high while out_ready toggles pseudo-randomly. Outputs must match a reference model in order, with no loss or duplication, and in_ready = 0 whenever both stages are full and out_ready = 0.
- Counter: 3 overflowing results consumed gives ovf_count = 3. clr_count in the same cycle as a 4th overflowing handshake gives 0. Preload to all-ones, then another overflowing handshake: count stays all-ones.
- Assert ap_rst with 2 transactions in flight: out_valid = 0 and ovf_count = 0 immediately. After release, no stale result appears and a new transaction completes with 2-cycle latency.
